// File: rtl/lut_layer_pkg.sv
// Shared types and elaboration helpers for the time-multiplexed LUT layer scheduler.
package lut_layer_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam int unsigned CONN_MAX_W = 4096;
    localparam int unsigned CONN_IDX_W = 12;

    // Index width with a floor of one bit so single-entry ranges still get a port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Feature index held in CONN slot `slot`, each slot `w` bits wide.
    function automatic int unsigned conn_slot(input logic [CONN_MAX_W-1:0] conn,
                                              input int unsigned slot,
                                              input int unsigned w);
        int unsigned v;
        v = 0;
        for (int unsigned b = 0; b < w; b++) begin
            v |= 32'(conn[CONN_IDX_W'(slot * w + b)]) << b;
        end
        return v;
    endfunction

endpackage

// File: rtl/lut_layer_gather.sv
// Selects the FANIN feature codes feeding neuron i_nidx from the latched input vector.
module lut_layer_gather
    import lut_layer_pkg::*;
#(
    parameter int unsigned IN_FEATS = 32,
    parameter int unsigned IN_BITS  = 2,
    parameter int unsigned NEURONS  = 16,
    parameter int unsigned FANIN    = 4,
    parameter logic [NEURONS*FANIN*idx_w(IN_FEATS)-1:0] CONN = '0
)(
    input  logic [IN_FEATS*IN_BITS-1:0] i_vec,
    input  logic [idx_w(NEURONS)-1:0]   i_nidx,
    output logic [FANIN*IN_BITS-1:0]    o_addr_c
);

    localparam int unsigned FEAT_W = idx_w(IN_FEATS);
    localparam int unsigned NIDX_W = idx_w(NEURONS);
    localparam int unsigned ROW_W  = FANIN * IN_BITS;
    localparam int unsigned CONN_W = NEURONS * FANIN * FEAT_W;

    logic [NEURONS*ROW_W-1:0] w_rows;

    if (CONN_W > CONN_MAX_W) begin : g_conn_too_wide
        $error("lut_layer_gather: CONN wider than CONN_MAX_W");
    end

    // Every row is wired statically from CONN; only the row select is dynamic.
    for (genvar gn = 0; gn < NEURONS; gn++) begin : g_row
        for (genvar gk = 0; gk < FANIN; gk++) begin : g_in
            localparam int unsigned SEL = conn_slot(CONN_MAX_W'(CONN), gn * FANIN + gk, FEAT_W);
            if (SEL >= IN_FEATS) begin : g_bad_conn
                $error("lut_layer_gather: CONN entry out of range");
            end
            assign w_rows[(gn*FANIN+gk)*IN_BITS +: IN_BITS] = i_vec[(SEL % IN_FEATS)*IN_BITS +: IN_BITS];
        end
    end

    always_comb begin
        o_addr_c = '0;
        for (int unsigned n = 0; n < NEURONS; n++) begin
            if (i_nidx == NIDX_W'(n)) begin
                o_addr_c = w_rows[n*ROW_W +: ROW_W];
            end
        end
    end

endmodule

// File: rtl/lut_layer_sched.sv
// Evaluates one LUT-neuron layer a neuron per cycle through a shared truth-table store,
// collecting the results into an output vector behind valid/ready handshakes.
module lut_layer_sched
    import lut_layer_pkg::*;
#(
    parameter int unsigned IN_FEATS = 32,
    parameter int unsigned IN_BITS  = 2,
    parameter int unsigned NEURONS  = 16,
    parameter int unsigned FANIN    = 4,
    parameter int unsigned OUT_BITS = 2,
    parameter logic [NEURONS*FANIN*idx_w(IN_FEATS)-1:0] CONN = '0
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_FEATS*IN_BITS-1:0]  in_vec,
    output logic                         lut_en,
    output logic [idx_w(NEURONS)-1:0]    lut_nidx,
    output logic [FANIN*IN_BITS-1:0]     lut_addr,
    input  logic [OUT_BITS-1:0]          lut_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NEURONS*OUT_BITS-1:0]  out_vec,
    output logic                         busy,
    output logic [15:0]                  done_cnt
);

    localparam int unsigned NIDX_W = idx_w(NEURONS);

    state_e                        r_state;
    state_e                        w_state_nxt;
    logic [IN_FEATS*IN_BITS-1:0]   r_vec;
    logic [NIDX_W-1:0]             r_cnt;
    logic                          r_ret_en;
    logic [NIDX_W-1:0]             r_ret_nidx;
    logic [NEURONS*OUT_BITS-1:0]   r_out_vec;
    logic [15:0]                   r_done_cnt;
    logic                          w_accept;
    logic                          w_release;
    logic                          w_last;

    assign w_last   = (r_cnt == NIDX_W'(NEURONS - 1));
    assign lut_nidx = r_cnt;
    assign out_vec  = r_out_vec;
    assign done_cnt = r_done_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs; clear overrides every handshake.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        lut_en      = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                w_accept = in_valid;
                if (in_valid) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                lut_en = 1'b1;
                if (w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                w_release = out_ready;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (clear) begin
            w_state_nxt = IDLE;
            w_accept    = 1'b0;
            w_release   = 1'b0;
        end
    end

    // Datapath: latched input, issue counter, one-cycle return tracking, result assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vec      <= '0;
            r_cnt      <= '0;
            r_ret_en   <= 1'b0;
            r_ret_nidx <= '0;
            r_out_vec  <= '0;
            r_done_cnt <= '0;
        end else begin
            r_ret_en   <= lut_en & ~clear;
            r_ret_nidx <= r_cnt;
            if (w_accept) begin
                r_vec <= in_vec;
            end
            if (lut_en && !w_last && !clear) begin
                r_cnt <= r_cnt + NIDX_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if (r_ret_en && !clear) begin
                for (int unsigned n = 0; n < NEURONS; n++) begin
                    if (r_ret_nidx == NIDX_W'(n)) begin
                        r_out_vec[n*OUT_BITS +: OUT_BITS] <= lut_data;
                    end
                end
            end
            if (w_release) begin
                r_done_cnt <= r_done_cnt + 16'd1;
            end
        end
    end

    lut_layer_gather #(
        .IN_FEATS (IN_FEATS),
        .IN_BITS  (IN_BITS),
        .NEURONS  (NEURONS),
        .FANIN    (FANIN),
        .CONN     (CONN)
    ) u_gather (
        .i_vec    (r_vec),
        .i_nidx   (r_cnt),
        .o_addr_c (lut_addr)
    );

endmodule
